// File: rtl/cpu_pkg.sv
// Shared datapath constants for the single-cycle CPU: widths, instruction field positions, opcodes.
package cpu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_N  = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned IMM_W  = 16;

    localparam int unsigned OP_LSB  = 26;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RD_LSB  = 16;
    localparam int unsigned RT_LSB  = 11;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [OP_W-1:0] OP_LUI  = 6'b111001;
    localparam logic [OP_W-1:0] OP_ANDI = 6'b110010;
    localparam logic [OP_W-1:0] OP_ORI  = 6'b110011;
    localparam logic [OP_W-1:0] OP_B    = 6'b111111;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b000000;
    localparam logic [OP_W-1:0] OP_BNE  = 6'b000001;

    function automatic logic [DATA_W-1:0] sign_ext16(input logic [IMM_W-1:0] v);
        return {{(DATA_W - IMM_W){v[IMM_W-1]}}, v};
    endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two async read ports, one sync write port, async active-low clear, R0 reads zero.
module register_file
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [REG_N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(REG_N); i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // R0 is forced to zero on read regardless of storage contents.
    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: register file, write-back mux, read-address mux and immediate extender.
// Optional write-first forwarding enabled by defining DECODE_WR_BYPASS_EN.
module decode_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] mem_out,
    input  logic              rf_wren,
    input  logic              rf_wrdata_sel,
    input  logic              rf_b_sel,
    output logic [DATA_W-1:0] immed,
    output logic [DATA_W-1:0] rfa,
    output logic [DATA_W-1:0] rfb
);

    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rt;
    logic [IMM_W-1:0]  imm16;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;

    assign opcode = instr[OP_LSB  +: OP_W];
    assign rs     = instr[RS_LSB  +: ADDR_W];
    assign rd     = instr[RD_LSB  +: ADDR_W];
    assign rt     = instr[RT_LSB  +: ADDR_W];
    assign imm16  = instr[IMM_LSB +: IMM_W];

    assign b_addr  = rf_b_sel ? rd : rt;
    assign wr_data = rf_wrdata_sel ? mem_out : alu_out;

    register_file u_rf (
        .clk     (clk),
        .rst_n   (reset),
        .we      (rf_wren),
        .waddr   (rd),
        .wdata   (wr_data),
        .raddr_a (rs),
        .raddr_b (b_addr),
        .rdata_a (rf_a),
        .rdata_b (rf_b)
    );

`ifdef DECODE_WR_BYPASS_EN
    logic wr_hit;

    // Forward the pending write to any read port addressing the same register.
    assign wr_hit = rf_wren && reset && (rd != '0);
    assign rfa    = (wr_hit && (rd == rs))     ? wr_data : rf_a;
    assign rfb    = (wr_hit && (rd == b_addr)) ? wr_data : rf_b;
`else
    assign rfa = rf_a;
    assign rfb = rf_b;
`endif

    // Immediate extension selected by opcode; everything unlisted sign-extends.
    always_comb begin
        immed = sign_ext16(imm16);
        case (opcode)
            OP_LUI:              immed = DATA_W'({imm16, IMM_W'(0)});
            OP_ANDI, OP_ORI:     immed = DATA_W'(imm16);
            OP_B, OP_BEQ, OP_BNE: immed = sign_ext16(imm16) << 2;
            default:             ;
        endcase
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_decode_stage;

    localparam logic [5:0] T_LUI  = 6'b111001;
    localparam logic [5:0] T_ANDI = 6'b110010;
    localparam logic [5:0] T_ORI  = 6'b110011;
    localparam logic [5:0] T_B    = 6'b111111;
    localparam logic [5:0] T_BEQ  = 6'b000000;
    localparam logic [5:0] T_BNE  = 6'b000001;
    localparam logic [5:0] T_ADDI = 6'b100000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] alu_out;
    logic [31:0] mem_out;
    logic        rf_wren;
    logic        rf_wrdata_sel;
    logic        rf_b_sel;
    logic [31:0] immed;
    logic [31:0] rfa;
    logic [31:0] rfb;

    logic [31:0] model [32];
    int n_total = 0;
    int n_pass  = 0;

    decode_stage dut (
        .clk           (clk),
        .reset         (reset),
        .instr         (instr),
        .alu_out       (alu_out),
        .mem_out       (mem_out),
        .rf_wren       (rf_wren),
        .rf_wrdata_sel (rf_wrdata_sel),
        .rf_b_sel      (rf_b_sel),
        .immed         (immed),
        .rfa           (rfa),
        .rfb           (rfb)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s,
                                       input logic [4:0] d, input logic [15:0] imm);
        return {op, s, d, imm};
    endfunction

    function automatic logic [31:0] wdata_now();
        return rf_wrdata_sel ? mem_out : alu_out;
    endfunction

    // Value a read port should show right now, from the architectural model.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (!reset || a == 5'd0) return 32'h0;
`ifdef DECODE_WR_BYPASS_EN
        if (rf_wren && instr[20:16] != 5'd0 && instr[20:16] == a) return wdata_now();
`endif
        return model[a];
    endfunction

    function automatic logic [31:0] exp_imm(input logic [5:0] op, input logic [15:0] imm);
        int s;
        int unsigned u;
        u = int'(imm);
        s = (u >= 32768) ? int'(u) - 65536 : int'(u);
        case (op)
            T_LUI:               return 32'(u * 65536);
            T_ANDI, T_ORI:       return 32'(u);
            T_B, T_BEQ, T_BNE:   return 32'(s * 4);
            default:             return 32'(s);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_model(input string tag);
        logic [4:0] b;
        b = rf_b_sel ? instr[20:16] : instr[15:11];
        check({tag, ".rfa"},   rfa,   exp_read(instr[25:21]));
        check({tag, ".rfb"},   rfb,   exp_read(b));
        check({tag, ".immed"}, immed, exp_imm(instr[31:26], instr[15:0]));
    endtask

    // Commit the pending write to the model, then advance one rising edge.
    task automatic tick();
        if (reset && rf_wren && instr[20:16] != 5'd0) model[instr[20:16]] = wdata_now();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    initial begin
        clear_model();
        reset = 1'b0; instr = mk(T_ADDI, 5'd5, 5'd9, 16'h4800);
        alu_out = 32'h1111_1111; mem_out = 32'h2222_2222;
        rf_wren = 1'b1; rf_wrdata_sel = 1'b0; rf_b_sel = 1'b0;
        #2;
        check("reset.rfa", rfa, 32'h0);
        check("reset.rfb", rfb, 32'h0);
        tick();
        check("reset_blocks_write", rfa, 32'h0);
        reset = 1'b1;
        rf_wren = 1'b0;
        tick();

        // Write then read R5 from both sources.
        instr = mk(T_ADDI, 5'd5, 5'd5, 16'h0000);
        rf_wren = 1'b1; rf_wrdata_sel = 1'b0; alu_out = 32'd12;
        tick();
        rf_wren = 1'b0; #1;
        check("r5_alu", rfa, 32'd12);
        rf_wren = 1'b1; rf_wrdata_sel = 1'b1; mem_out = 32'd23;
        tick();
        rf_wren = 1'b0; #1;
        check("r5_mem", rfa, 32'd23);

        // R0 protection.
        instr = mk(T_ADDI, 5'd0, 5'd0, 16'h0000);
        rf_wren = 1'b1; rf_wrdata_sel = 1'b0; alu_out = 32'hDEAD_BEEF;
        tick();
        rf_wren = 1'b0; #1;
        check("r0_zero", rfa, 32'h0);

        // Second read-address select.
        rf_wren = 1'b1; rf_wrdata_sel = 1'b0;
        instr = mk(T_ADDI, 5'd0, 5'd3, 16'h0000); alu_out = 32'd7; tick();
        instr = mk(T_ADDI, 5'd0, 5'd9, 16'h0000); alu_out = 32'd4; tick();
        rf_wren = 1'b0;
        instr = mk(T_ADDI, 5'd0, 5'd3, {5'd9, 11'd0});
        rf_b_sel = 1'b1; #1;
        check("bsel_rd", rfb, 32'd7);
        rf_b_sel = 1'b0; #1;
        check("bsel_rt", rfb, 32'd4);

        // Immediate extension.
        instr = mk(T_ADDI, 5'd0, 5'd0, 16'h8004); #1; check("imm_addi", immed, 32'hFFFF_8004);
        instr = mk(T_ORI,  5'd0, 5'd0, 16'h8004); #1; check("imm_ori",  immed, 32'h0000_8004);
        instr = mk(T_LUI,  5'd0, 5'd0, 16'h8004); #1; check("imm_lui",  immed, 32'h8004_0000);
        instr = mk(T_BEQ,  5'd0, 5'd0, 16'h8004); #1; check("imm_beq",  immed, 32'hFFFE_0010);
        instr = mk(T_ANDI, 5'd0, 5'd0, 16'hF00F); #1; check("imm_andi", immed, 32'h0000_F00F);
        instr = mk(T_BNE,  5'd0, 5'd0, 16'h0003); #1; check("imm_bne",  immed, 32'h0000_000C);
        instr = mk(T_B,    5'd0, 5'd0, 16'hFFFF); #1; check("imm_b",    immed, 32'hFFFF_FFFC);

        // Write enable low holds the target over several edges.
        instr = mk(T_ADDI, 5'd5, 5'd5, 16'h0000);
        rf_wren = 1'b0; alu_out = 32'hAAAA_5555; mem_out = 32'h5555_AAAA; rf_wrdata_sel = 1'b1;
        tick(); tick(); tick();
        check("wren_low_hold", rfa, 32'd23);

        // Same-cycle write and read of R7.
        instr = mk(T_ADDI, 5'd0, 5'd7, 16'h0000);
        rf_wren = 1'b1; rf_wrdata_sel = 1'b0; alu_out = 32'h0000_0111; tick();
        instr = mk(T_ADDI, 5'd7, 5'd7, 16'h0000);
        alu_out = 32'h0000_0222; #1;
`ifdef DECODE_WR_BYPASS_EN
        check("r7_same_cycle", rfa, 32'h0000_0222);
`else
        check("r7_same_cycle", rfa, 32'h0000_0111);
`endif
        tick();
        rf_wren = 1'b0; #1;
        check("r7_after_edge", rfa, 32'h0000_0222);

        // Mid-run reset pulse clears every register before any edge.
        @(negedge clk); #1;
        reset = 1'b0; #1;
        clear_model();
        for (int a = 0; a < 32; a++) begin
            instr = mk(T_ADDI, 5'(a), 5'd0, {5'(a), 11'd0});
            #0.1;
            check("midreset.rfa", rfa, 32'h0);
        end
        check("midreset.rfb", rfb, 32'h0);
        reset = 1'b1;
        tick();

        // Randomized traffic against the model.
        for (int it = 0; it < 400; it++) begin
            instr         = $urandom;
            if ($urandom_range(0, 3) == 0) instr[31:26] = T_ADDI ^ 6'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) instr[20:16] = instr[25:21];
            alu_out       = $urandom;
            mem_out       = $urandom;
            rf_wren       = 1'($urandom_range(0, 1));
            rf_wrdata_sel = 1'($urandom_range(0, 1));
            rf_b_sel      = 1'($urandom_range(0, 1));
            #1;
            check_model("rand");
            tick();
            if (it % 100 == 99) begin
                reset = 1'b0; #1;
                clear_model();
                check_model("rand_reset");
                @(negedge clk);
                reset = 1'b1;
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
